// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   EX-stage branch/JAL resolver with a direct-mapped BTB of 2-bit
//   saturating counters that gives IF a taken/target prediction per fetch PC.
//
//   Ports
//     clk, rst_n                 clock, asynchronous active-low reset
//     F_PC                       fetch PC to predict
//     F_PredTaken, F_PredTarget  combinational prediction for F_PC
//     Ex_Valid, Cur_PC, Imm,     EX-stage instruction, branch condition (AluResult[0]),
//     Branch, AluResult, jals,   and the prediction it was fetched with
//     Ex_PredTaken, Ex_PredTarget
//     PC_Imm, PC_Four, BrPC      target, fall-through, and correct next PC
//     PcSel, Flush, JalSel       redirect on mispredict, kill IF/ID, JAL indicator
//     Perf_Branches, Perf_Mispred  performance counters
//
//   Build option: define BP_PERF_EN to build the performance counters;
//   otherwise both Perf_* outputs are tied to zero.
module branch_predict_unit #(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] F_PC,
  output logic            F_PredTaken,
  output logic [31:0]     F_PredTarget,
  input  logic            Ex_Valid,
  input  logic [PC_W-1:0] Cur_PC,
  input  logic [31:0]     Imm,
  input  logic            Branch,
  input  logic [31:0]     AluResult,
  input  logic            jals,
  input  logic            Ex_PredTaken,
  input  logic [31:0]     Ex_PredTarget,
  output logic [31:0]     PC_Imm,
  output logic [31:0]     PC_Four,
  output logic [31:0]     BrPC,
  output logic            PcSel,
  output logic            Flush,
  output logic            JalSel,
  output logic [31:0]     Perf_Branches,
  output logic [31:0]     Perf_Mispred
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic [ENTRIES-1:0]            vld_q;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
  logic [ENTRIES-1:0][PC_W-1:0]  tgt_q;
  logic [ENTRIES-1:0][1:0]       ctr_q;

  // ---------------- lookup (IF) ----------------
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx        = F_PC[IDX_W+1:2];
  assign f_tag        = F_PC[PC_W-1:IDX_W+2];
  assign f_hit        = vld_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign F_PredTaken  = f_hit && ctr_q[f_idx][1];
  assign F_PredTarget = F_PredTaken ? {{(32-PC_W){1'b0}}, tgt_q[f_idx]}
                                    : {{(32-PC_W){1'b0}}, F_PC} + 32'd4;

  // ---------------- resolve (EX) ----------------
  logic is_cti, act_taken, mispred;

  assign is_cti    = Branch || jals;
  assign act_taken = (Branch && AluResult[0]) || jals;
  assign PC_Imm    = {{(32-PC_W){1'b0}}, Cur_PC} + Imm;
  assign PC_Four   = {{(32-PC_W){1'b0}}, Cur_PC} + 32'd4;
  // A non-branch has act_taken=0, so an aliased taken prediction falls back to PC_Four.
  assign BrPC      = act_taken ? PC_Imm : PC_Four;
  assign JalSel    = jals;

  always_comb begin
    mispred = 1'b0;
    if (Ex_Valid) begin
      if (is_cti) mispred = (act_taken != Ex_PredTaken) ||
                            (act_taken && (Ex_PredTarget != PC_Imm));
      else        mispred = Ex_PredTaken;
    end
  end

  assign PcSel = mispred;
  assign Flush = mispred;

  // ---------------- update ----------------
  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  logic             e_hit, upd_en, wr_en;
  logic [1:0]       e_ctr, ctr_nxt;

  assign e_idx  = Cur_PC[IDX_W+1:2];
  assign e_tag  = Cur_PC[PC_W-1:IDX_W+2];
  assign e_hit  = vld_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign e_ctr  = ctr_q[e_idx];
  assign upd_en = Ex_Valid && is_cti;
  // Misses only allocate when taken; not-taken misses leave the table alone.
  assign wr_en  = upd_en && (e_hit || act_taken);

  always_comb begin
    ctr_nxt = jals ? 2'b11 : 2'b10;
    if (e_hit) begin
      if (act_taken) ctr_nxt = (e_ctr == 2'b11) ? e_ctr : e_ctr + 2'd1;
      else           ctr_nxt = (e_ctr == 2'b00) ? e_ctr : e_ctr - 2'd1;
    end
  end

  // Hit and allocate share one write: on a hit valid/tag are rewritten unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        vld_q[i] <= 1'b0;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'b01;
      end
    end else if (wr_en) begin
      vld_q[e_idx] <= 1'b1;
      tag_q[e_idx] <= e_tag;
      ctr_q[e_idx] <= ctr_nxt;
      if (act_taken) tgt_q[e_idx] <= PC_Imm[PC_W-1:0];
    end
  end

  // Only the condition bit of the ALU result is meaningful here.
  logic unused_alu;
  assign unused_alu = ^AluResult[31:1];

  // ---------------- performance counters ----------------
`ifdef BP_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Perf_Branches <= '0;
      Perf_Mispred  <= '0;
    end else begin
      if (upd_en)  Perf_Branches <= Perf_Branches + 32'd1;
      if (mispred) Perf_Mispred  <= Perf_Mispred + 32'd1;
    end
  end
`else
  assign Perf_Branches = '0;
  assign Perf_Mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;
  localparam int PC_W = 9;
  localparam int ENTRIES = 16;

  logic        clk, rst_n;
  logic [8:0]  F_PC, Cur_PC;
  logic        F_PredTaken, Ex_Valid, Branch, jals, Ex_PredTaken;
  logic [31:0] F_PredTarget, Imm, AluResult, Ex_PredTarget;
  logic [31:0] PC_Imm, PC_Four, BrPC, Perf_Branches, Perf_Mispred;
  logic        PcSel, Flush, JalSel;

  branch_predict_unit #(.PC_W(PC_W), .ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst_n(rst_n), .F_PC(F_PC), .F_PredTaken(F_PredTaken),
    .F_PredTarget(F_PredTarget), .Ex_Valid(Ex_Valid), .Cur_PC(Cur_PC), .Imm(Imm),
    .Branch(Branch), .AluResult(AluResult), .jals(jals), .Ex_PredTaken(Ex_PredTaken),
    .Ex_PredTarget(Ex_PredTarget), .PC_Imm(PC_Imm), .PC_Four(PC_Four), .BrPC(BrPC),
    .PcSel(PcSel), .Flush(Flush), .JalSel(JalSel), .Perf_Branches(Perf_Branches),
    .Perf_Mispred(Perf_Mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  logic [15:0]     m_vld;
  logic [2:0]      m_tag [16];
  logic [8:0]      m_tgt [16];
  logic [1:0]      m_ctr [16];
  logic [31:0]     m_pb, m_pm;

  function automatic void m_reset();
    m_vld = '0; m_pb = '0; m_pm = '0;
    for (int i = 0; i < 16; i++) begin m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 2'b01; end
  endfunction

  function automatic void m_look(input logic [8:0] pc, output logic pt, output logic [31:0] tgt);
    logic [3:0] ix;
    ix  = pc[5:2];
    pt  = m_vld[ix] && (m_tag[ix] == pc[8:6]) && m_ctr[ix][1];
    tgt = pt ? {23'b0, m_tgt[ix]} : {23'b0, pc} + 32'd4;
  endfunction

  typedef struct {
    logic        pt, pcsel, jal;
    logic [31:0] ptgt, pc_imm, pc_four, brpc, pb, pm;
  } exp_t;
  exp_t sbq[$];

  // Scoreboard consumer: outputs sampled mid-cycle against queued expectations.
  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("pred_taken",  {31'b0, F_PredTaken}, {31'b0, e.pt});
      chk("pred_target", F_PredTarget, e.ptgt);
      chk("pc_imm",      PC_Imm, e.pc_imm);
      chk("pc_four",     PC_Four, e.pc_four);
      chk("brpc",        BrPC, e.brpc);
      chk("pcsel",       {31'b0, PcSel}, {31'b0, e.pcsel});
      chk("flush",       {31'b0, Flush}, {31'b0, e.pcsel});
      chk("jalsel",      {31'b0, JalSel}, {31'b0, e.jal});
      chk("perf_br",     Perf_Branches, e.pb);
      chk("perf_mis",    Perf_Mispred, e.pm);
    end
  end

  task automatic drive(input logic [8:0] fpc, input logic ev, input logic [8:0] cur,
                       input logic [31:0] imm, input logic br, input logic alu0,
                       input logic jal, input logic ept, input logic [31:0] eptgt);
    exp_t e;
    logic act, mis, hit;
    logic [3:0] ix;
    @(posedge clk); #1;
    F_PC = fpc; Ex_Valid = ev; Cur_PC = cur; Imm = imm; Branch = br;
    AluResult = {$urandom} & 32'hFFFF_FFFE | {31'b0, alu0};
    jals = jal; Ex_PredTaken = ept; Ex_PredTarget = eptgt;
    m_look(fpc, e.pt, e.ptgt);
    e.pc_imm  = {23'b0, cur} + imm;
    e.pc_four = {23'b0, cur} + 32'd4;
    act       = (br && alu0) || jal;
    e.brpc    = act ? e.pc_imm : e.pc_four;
    if (br || jal) mis = ev && ((act != ept) || (act && eptgt != e.pc_imm));
    else           mis = ev && ept;
    e.pcsel = mis;
    e.jal   = jal;
`ifdef BP_PERF_EN
    e.pb = m_pb; e.pm = m_pm;
`else
    e.pb = '0; e.pm = '0;
`endif
    sbq.push_back(e);
    @(negedge clk);
    // model the update the DUT performs on the coming posedge
    if (ev && (br || jal)) begin
      ix  = cur[5:2];
      hit = m_vld[ix] && (m_tag[ix] == cur[8:6]);
      if (hit) begin
        if (act) begin
          if (m_ctr[ix] != 2'b11) m_ctr[ix] = m_ctr[ix] + 2'd1;
          m_tgt[ix] = e.pc_imm[8:0];
        end else if (m_ctr[ix] != 2'b00) m_ctr[ix] = m_ctr[ix] - 2'd1;
      end else if (act) begin
        m_vld[ix] = 1'b1; m_tag[ix] = cur[8:6]; m_tgt[ix] = e.pc_imm[8:0];
        m_ctr[ix] = jal ? 2'b11 : 2'b10;
      end
      m_pb = m_pb + 32'd1;
    end
    if (mis) m_pm = m_pm + 32'd1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0]  cur, fpc;
    logic [31:0] imm, eptgt;
    logic        ept, ev;
    int          typ;
    m_reset();
    rst_n = 1'b0; F_PC = '0; Ex_Valid = 0; Cur_PC = '0; Imm = '0; Branch = 0;
    AluResult = '0; jals = 0; Ex_PredTaken = 0; Ex_PredTarget = '0;
    #12 rst_n = 1'b1;

    // reset state
    drive(9'h010, 0, 9'h000, 32'h0, 0, 0, 0, 0, 32'h0);
    chk("rst_pt", {31'b0, F_PredTaken}, 32'h0);
    chk("rst_tgt", F_PredTarget, 32'h14);
    chk("rst_perf", Perf_Branches | Perf_Mispred, 32'h0);

    // cold taken branch
    drive(9'h010, 1, 9'h020, 32'h10, 1, 1, 0, 0, 32'h24);
    chk("cold_brpc", BrPC, 32'h30);
    chk("cold_pcsel", {31'b0, PcSel}, 32'h1);
    drive(9'h020, 0, 9'h000, 32'h0, 0, 0, 0, 0, 32'h0);
    chk("cold_pt", {31'b0, F_PredTaken}, 32'h1);
    chk("cold_tgt", F_PredTarget, 32'h30);

    // not taken three times
    drive(9'h020, 1, 9'h020, 32'h10, 1, 0, 0, 1, 32'h30);
    chk("nt1_pcsel", {31'b0, PcSel}, 32'h1);
    drive(9'h020, 1, 9'h020, 32'h10, 1, 0, 0, 0, 32'h24);
    chk("nt2_pt", {31'b0, F_PredTaken}, 32'h0);
    chk("nt2_pcsel", {31'b0, PcSel}, 32'h0);
    drive(9'h020, 1, 9'h020, 32'h10, 1, 0, 0, 0, 32'h24);
    chk("nt3_pcsel", {31'b0, PcSel}, 32'h0);

    // JAL with negative offset, first as a bubble
    drive(9'h040, 0, 9'h040, 32'hFFFF_FFF8, 0, 0, 1, 0, 32'h44);
    chk("jal_pcimm", PC_Imm, 32'h38);
    chk("jal_sel", {31'b0, JalSel}, 32'h1);
    chk("jal_bubble_pcsel", {31'b0, PcSel}, 32'h0);
    drive(9'h040, 1, 9'h040, 32'hFFFF_FFF8, 0, 0, 1, 0, 32'h44);
    chk("jal_noupd_pt", {31'b0, F_PredTaken}, 32'h0);
    drive(9'h040, 0, 9'h000, 32'h0, 0, 0, 0, 0, 32'h0);
    chk("jal_pt", {31'b0, F_PredTaken}, 32'h1);
    chk("jal_tgt", F_PredTarget, 32'h38);

    // same index, different tag: second evicts first
    drive(9'h004, 1, 9'h004, 32'h20, 1, 1, 0, 0, 32'h8);
    drive(9'h004, 1, 9'h044, 32'h20, 1, 1, 0, 0, 32'h48);
    drive(9'h004, 0, 9'h000, 32'h0, 0, 0, 0, 0, 32'h0);
    chk("evict_old_pt", {31'b0, F_PredTaken}, 32'h0);
    drive(9'h044, 0, 9'h000, 32'h0, 0, 0, 0, 0, 32'h0);
    chk("evict_new_tgt", F_PredTarget, 32'h64);

    // mid-run reset clears table and counters immediately
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("mrst_pt", {31'b0, F_PredTaken}, 32'h0);
    chk("mrst_tgt", F_PredTarget, 32'h48);
    chk("mrst_perf", Perf_Branches | Perf_Mispred, 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;

    // random traffic over a small PC range to force hits, aliasing and evictions
    for (int i = 0; i < 300; i++) begin
      cur = 9'($urandom_range(0, 63) * 4);
      fpc = ($urandom_range(0, 1) == 1) ? cur : 9'($urandom_range(0, 63) * 4);
      typ = $urandom_range(0, 2);
      imm = 32'($urandom_range(0, 63) * 4) - 32'd128;
      if ($urandom_range(0, 3) != 0) m_look(cur, ept, eptgt);
      else begin
        ept   = 1'($urandom_range(0, 1));
        eptgt = 32'($urandom_range(0, 127) * 4);
      end
      ev = ($urandom_range(0, 9) != 0);
      drive(fpc, ev, cur, imm, typ == 1, 1'($urandom_range(0, 1)), typ == 2, ept, eptgt);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
